// File: rtl/german_pkg.sv
// Shared encodings for the parametrised German coherence system.
// Cache and message structs are built per DATA_W inside the modules.
package german_pkg;

    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_S = 2'd1,
        ST_E = 2'd2
    } cache_state_e;

    typedef enum logic [2:0] {
        CMD_EMPTY  = 3'd0,
        CMD_REQS   = 3'd1,
        CMD_REQE   = 3'd2,
        CMD_INV    = 3'd3,
        CMD_INVACK = 3'd4,
        CMD_GNTS   = 3'd5,
        CMD_GNTE   = 3'd6
    } msg_cmd_e;

    typedef enum logic [3:0] {
        R_STORE       = 4'd0,
        R_SEND_REQS   = 4'd1,
        R_SEND_REQE   = 4'd2,
        R_RECV_REQS   = 4'd3,
        R_RECV_REQE   = 4'd4,
        R_SEND_INV    = 4'd5,
        R_SEND_INVACK = 4'd6,
        R_RECV_INVACK = 4'd7,
        R_SEND_GNTS   = 4'd8,
        R_SEND_GNTE   = 4'd9,
        R_RECV_GNTS   = 4'd10,
        R_RECV_GNTE   = 4'd11
    } rule_id_e;

    localparam int RULE_CNT = 12;

    function automatic int node_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Flat width of one node slice: cache, chan1 cmd, chan2, chan3, sets.
    function automatic int node_bits(input int dw);
        return 13 + 3 * dw;
    endfunction

endpackage

// File: rtl/german_node_slice.sv
// Per-node state: cache line, three channels, InvSet and ShrSet bits.
// The top decodes rules and hands each slice a write strobe and value.
module german_node_slice
    import german_pkg::*;
#(
    parameter int                DATA_W    = 2,
    parameter logic [DATA_W-1:0] INIT_DATA = '0,
    parameter int                NB        = node_bits(DATA_W)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we_i,
    input  logic [NB-1:0] node_d_i,
    output logic [NB-1:0] node_q_o
);

    typedef struct packed {
        cache_state_e      st;
        logic [DATA_W-1:0] data;
    } cache_t;

    typedef struct packed {
        msg_cmd_e          cmd;
        logic [DATA_W-1:0] data;
    } msg_t;

    typedef struct packed {
        cache_t   cache;
        msg_cmd_e c1;
        msg_t     c2;
        msg_t     c3;
        logic     inv;
        logic     shr;
    } node_t;

    localparam node_t RST = '{
        cache: '{st: ST_I, data: INIT_DATA},
        c1:    CMD_EMPTY,
        c2:    '{cmd: CMD_EMPTY, data: INIT_DATA},
        c3:    '{cmd: CMD_EMPTY, data: INIT_DATA},
        inv:   1'b0,
        shr:   1'b0
    };

    node_t node_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            node_q <= RST;
        end else if (we_i) begin
            node_q <= node_d_i;
        end
    end

    assign node_q_o = node_q;

endmodule

// File: rtl/german_sys_param.sv
// German coherence system: one guarded rule per cycle plus invariants.
// Macro GERMAN_FIRE_CNT_EN enables the saturating fire_cnt counter.
module german_sys_param
    import german_pkg::*;
#(
    parameter int                NUM_NODES = 3,
    parameter int                DATA_W    = 2,
    parameter int                NODE_W    = node_w(NUM_NODES),
    parameter logic [DATA_W-1:0] INIT_DATA = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rule_valid,
    input  logic [3:0]             rule_id,
    input  logic [NODE_W-1:0]      rule_node,
    input  logic [DATA_W-1:0]      store_data,
    output logic                   fired,
    output logic                   illegal_sel,
    output logic [2*NUM_NODES-1:0] cache_state,
    output logic [2:0]             cur_cmd,
    output logic                   ex_gntd,
    output logic                   ctrl_ok,
    output logic                   data_ok,
    output logic [15:0]            fire_cnt
);

    localparam int NB = node_bits(DATA_W);

    typedef struct packed {
        cache_state_e      st;
        logic [DATA_W-1:0] data;
    } cache_t;

    typedef struct packed {
        msg_cmd_e          cmd;
        logic [DATA_W-1:0] data;
    } msg_t;

    typedef struct packed {
        cache_t   cache;
        msg_cmd_e c1;
        msg_t     c2;
        msg_t     c3;
        logic     inv;
        logic     shr;
    } node_t;

    node_t                node_q [NUM_NODES];
    node_t                node_d [NUM_NODES];
    logic [NUM_NODES-1:0] node_we;

    msg_cmd_e          cur_cmd_q, cur_cmd_d;
    logic [NODE_W-1:0] cur_ptr_q, cur_ptr_d;
    logic              ex_gntd_q, ex_gntd_d;
    logic [DATA_W-1:0] mem_q, mem_d;
    logic [DATA_W-1:0] aux_q, aux_d;

    rule_id_e rid;
    logic     id_ok, node_ok, sel_ok;
    logic     guard, ptr_hit, any_shr, copy_inv;
    node_t    sel_n, upd_n;

    for (genvar i = 0; i < NUM_NODES; i++) begin : g_node
        german_node_slice #(
            .DATA_W    (DATA_W),
            .INIT_DATA (INIT_DATA),
            .NB        (NB)
        ) u_slice (
            .clock    (clock),
            .reset    (reset),
            .we_i     (node_we[i]),
            .node_d_i (node_d[i]),
            .node_q_o (node_q[i])
        );
    end

    assign rid         = rule_id_e'(rule_id);
    assign id_ok       = rule_id < 4'(RULE_CNT);
    assign node_ok     = int'(rule_node) < NUM_NODES;
    assign sel_ok      = id_ok & node_ok;
    assign illegal_sel = rule_valid & ~sel_ok;
    assign ptr_hit     = cur_ptr_q == rule_node;
    assign fired       = rule_valid & sel_ok & guard;

    always_comb begin
        sel_n   = node_q[0];
        any_shr = 1'b0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (rule_node == NODE_W'(i)) sel_n = node_q[i];
            any_shr = any_shr | node_q[i].shr;
        end
    end

    always_comb begin
        guard = 1'b0;
        unique case (rid)
            R_STORE:
                guard = sel_n.cache.st == ST_E;
            R_SEND_REQS:
                guard = sel_n.c1 == CMD_EMPTY && sel_n.cache.st == ST_I;
            R_SEND_REQE:
                guard = sel_n.c1 == CMD_EMPTY &&
                        (sel_n.cache.st == ST_I || sel_n.cache.st == ST_S);
            R_RECV_REQS:
                guard = cur_cmd_q == CMD_EMPTY && sel_n.c1 == CMD_REQS;
            R_RECV_REQE:
                guard = cur_cmd_q == CMD_EMPTY && sel_n.c1 == CMD_REQE;
            R_SEND_INV:
                guard = sel_n.c2.cmd == CMD_EMPTY && sel_n.inv &&
                        (cur_cmd_q == CMD_REQE ||
                         (cur_cmd_q == CMD_REQS && ex_gntd_q));
            R_SEND_INVACK:
                guard = sel_n.c2.cmd == CMD_INV && sel_n.c3.cmd == CMD_EMPTY;
            R_RECV_INVACK:
                guard = sel_n.c3.cmd == CMD_INVACK && cur_cmd_q != CMD_EMPTY;
            R_SEND_GNTS:
                guard = cur_cmd_q == CMD_REQS && ptr_hit &&
                        sel_n.c2.cmd == CMD_EMPTY && !ex_gntd_q;
            R_SEND_GNTE:
                guard = cur_cmd_q == CMD_REQE && ptr_hit &&
                        sel_n.c2.cmd == CMD_EMPTY && !ex_gntd_q && !any_shr;
            R_RECV_GNTS:
                guard = sel_n.c2.cmd == CMD_GNTS;
            R_RECV_GNTE:
                guard = sel_n.c2.cmd == CMD_GNTE;
            default:
                guard = 1'b0;
        endcase
    end

    always_comb begin
        upd_n     = sel_n;
        copy_inv  = 1'b0;
        cur_cmd_d = cur_cmd_q;
        cur_ptr_d = cur_ptr_q;
        ex_gntd_d = ex_gntd_q;
        mem_d     = mem_q;
        aux_d     = aux_q;
        if (fired) begin
            unique case (rid)
                R_STORE: begin
                    upd_n.cache.data = store_data;
                    aux_d            = store_data;
                end
                R_SEND_REQS: upd_n.c1 = CMD_REQS;
                R_SEND_REQE: upd_n.c1 = CMD_REQE;
                R_RECV_REQS, R_RECV_REQE: begin
                    cur_cmd_d = (rid == R_RECV_REQS) ? CMD_REQS : CMD_REQE;
                    cur_ptr_d = rule_node;
                    upd_n.c1  = CMD_EMPTY;
                    copy_inv  = 1'b1;
                end
                R_SEND_INV: begin
                    upd_n.c2.cmd = CMD_INV;
                    upd_n.inv    = 1'b0;
                end
                R_SEND_INVACK: begin
                    upd_n.c2.cmd = CMD_EMPTY;
                    upd_n.c3.cmd = CMD_INVACK;
                    if (sel_n.cache.st == ST_E) upd_n.c3.data = sel_n.cache.data;
                    upd_n.cache.st   = ST_I;
                    upd_n.cache.data = INIT_DATA;
                end
                R_RECV_INVACK: begin
                    upd_n.c3.cmd = CMD_EMPTY;
                    upd_n.shr    = 1'b0;
                    if (ex_gntd_q) begin
                        ex_gntd_d = 1'b0;
                        mem_d     = sel_n.c3.data;
                    end
                end
                R_SEND_GNTS, R_SEND_GNTE: begin
                    upd_n.c2.cmd  = (rid == R_SEND_GNTS) ? CMD_GNTS : CMD_GNTE;
                    upd_n.c2.data = mem_q;
                    upd_n.shr     = 1'b1;
                    cur_cmd_d     = CMD_EMPTY;
                    if (rid == R_SEND_GNTE) ex_gntd_d = 1'b1;
                end
                R_RECV_GNTS, R_RECV_GNTE: begin
                    upd_n.cache.st   = (rid == R_RECV_GNTS) ? ST_S : ST_E;
                    upd_n.cache.data = sel_n.c2.data;
                    upd_n.c2.cmd     = CMD_EMPTY;
                end
                default: ;
            endcase
        end
        // InvSet snapshot of ShrSet must cover every node, selected one too
        for (int i = 0; i < NUM_NODES; i++) begin
            node_d[i]  = node_q[i];
            node_we[i] = 1'b0;
            if (fired && rule_node == NODE_W'(i)) begin
                node_d[i]  = upd_n;
                node_we[i] = 1'b1;
            end
            if (copy_inv) begin
                node_d[i].inv = node_q[i].shr;
                node_we[i]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_cmd_q <= CMD_EMPTY;
            cur_ptr_q <= '0;
            ex_gntd_q <= 1'b0;
            mem_q     <= INIT_DATA;
            aux_q     <= INIT_DATA;
        end else begin
            cur_cmd_q <= cur_cmd_d;
            cur_ptr_q <= cur_ptr_d;
            ex_gntd_q <= ex_gntd_d;
            mem_q     <= mem_d;
            aux_q     <= aux_d;
        end
    end

    always_comb begin
        ctrl_ok = 1'b1;
        data_ok = ex_gntd_q || (mem_q == aux_q);
        for (int i = 0; i < NUM_NODES; i++) begin
            cache_state[2*i +: 2] = node_q[i].cache.st;
            if (node_q[i].cache.st != ST_I && node_q[i].cache.data != aux_q)
                data_ok = 1'b0;
            for (int j = 0; j < NUM_NODES; j++) begin
                if (i != j && node_q[i].cache.st == ST_E && node_q[j].cache.st != ST_I)
                    ctrl_ok = 1'b0;
            end
        end
    end

    assign cur_cmd = cur_cmd_q;
    assign ex_gntd = ex_gntd_q;

`ifdef GERMAN_FIRE_CNT_EN
    logic [15:0] fire_cnt_q, fire_cnt_d;

    assign fire_cnt_d = (fired && fire_cnt_q != 16'hFFFF) ? fire_cnt_q + 16'd1
                                                          : fire_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) fire_cnt_q <= 16'd0;
        else       fire_cnt_q <= fire_cnt_d;
    end

    assign fire_cnt = fire_cnt_q;
`else
    assign fire_cnt = 16'd0;
`endif

endmodule

// File: doc/german_sys_param.md
Name: german_sys_param

Overview:
- Parametrised successor to the fixed 3-node German cache-coherence system model generated from Murphi.
- Supports NUM_NODES caches and DATA_W-bit data.
- Rules are selected by an explicit valid/rule/node interface instead of a one-hot-style enable word; exactly one rule is applied atomically per cycle.
- Adds a guard-result output, illegal-selection detection and on-line coherence invariant flags for equivalence and formal checking against the Murphi model.

Parameters:
- NUM_NODES, 3, number of caches/nodes (>=2).
- DATA_W, 2, width of data values.
- NODE_W, max(1,clog2(NUM_NODES)), width of the node index (derived).
- INIT_DATA, 0, reset value of MemData, AuxData and all data fields.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rule_valid  in  1  apply the selected rule this cycle.
- rule_id  in  4  0 Store, 1 SendReqS, 2 SendReqE, 3 RecvReqS, 4 RecvReqE, 5 SendInv, 6 SendInvAck, 7 RecvInvAck, 8 SendGntS, 9 SendGntE, 10 RecvGntS, 11 RecvGntE.
- rule_node  in  NODE_W  target node i.
- store_data  in  DATA_W  value d for Store.
- fired  out  1  combinational: rule_valid & legal & guard true; the state updates at the next edge.
- illegal_sel  out  1  combinational: rule_valid & (rule_id>11 | rule_node>=NUM_NODES).
- cache_state  out  2*NUM_NODES  packed cache states; node 0 in the LSBs.
- cur_cmd  out  3  CurCmd.
- ex_gntd  out  1  ExGntd.
- ctrl_ok  out  1  combinational control invariant.
- data_ok  out  1  combinational data invariant.
- fire_cnt  out  16  see Optional Feature.

Behaviour:
- Encodings:
  - Cache state: I=0, S=1, E=2.
  - Cmd: Empty=0, ReqS=1, ReqE=2, Inv=3, InvAck=4, GntS=5, GntE=6.
- State:
  - Per node: Cache{State,Data}, Chan1/Chan2/Chan3{Cmd,Data}, InvSet, ShrSet.
  - Global: CurCmd, CurPtr, ExGntd, MemData, AuxData.
- Reset (asynchronous, immediate):
  - All States I; all Cmds Empty; all Sets 0.
  - ExGntd 0; CurPtr 0; all data INIT_DATA.
  - Outputs after reset: fired/illegal_sel follow inputs; ctrl_ok=data_ok=1; fire_cnt=0.
- Rules for node i; updates occur only when fired; all other state holds:
  - Store: guard State[i]=E. Cache[i].Data:=d; AuxData:=d.
  - SendReqS: guard Chan1[i].Cmd=Empty & State[i]=I. Chan1[i].Cmd:=ReqS.
  - SendReqE: guard Chan1[i].Cmd=Empty & State[i] in {I,S}. Chan1[i].Cmd:=ReqE.
  - RecvReqS/RecvReqE: guard CurCmd=Empty & Chan1[i].Cmd=ReqS/ReqE.
    - CurCmd:=that cmd; CurPtr:=i; Chan1[i].Cmd:=Empty.
    - InvSet[j]:=ShrSet[j] for all j.
  - SendInv: guard Chan2[i].Cmd=Empty & InvSet[i] & (CurCmd=ReqE | (CurCmd=ReqS & ExGntd)).
    - Chan2[i].Cmd:=Inv; InvSet[i]:=0.
  - SendInvAck: guard Chan2[i].Cmd=Inv & Chan3[i].Cmd=Empty.
    - Chan2[i].Cmd:=Empty; Chan3[i].Cmd:=InvAck.
    - If State[i]=E: Chan3[i].Data:=Cache[i].Data.
    - State[i]:=I; Cache[i].Data:=INIT_DATA.
  - RecvInvAck: guard Chan3[i].Cmd=InvAck & CurCmd!=Empty.
    - Chan3[i].Cmd:=Empty; ShrSet[i]:=0.
    - If ExGntd: ExGntd:=0 and MemData:=Chan3[i].Data.
  - SendGntS: guard CurCmd=ReqS & CurPtr=i & Chan2[i].Cmd=Empty & !ExGntd.
    - Chan2[i]:={GntS,MemData}; ShrSet[i]:=1; CurCmd:=Empty.
  - SendGntE: guard CurCmd=ReqE & CurPtr=i & Chan2[i].Cmd=Empty & !ExGntd & no ShrSet bit set.
    - As SendGntS but Cmd GntE; ExGntd:=1.
  - RecvGntS/RecvGntE: guard Chan2[i].Cmd=GntS/GntE.
    - State[i]:=S/E; Cache[i].Data:=Chan2[i].Data; Chan2[i].Cmd:=Empty.
- Selection rules:
  - An illegal selection or a false guard is a no-op; there is no error state.
  - A rule's writes all take effect at one edge; its guard reads pre-edge state only.
- Invariants:
  - ctrl_ok = 0 iff, for some i!=j, State[i]=E & State[j]!=I.
  - data_ok = 0 iff (!ExGntd & MemData!=AuxData) or, for some i, State[i]!=I & Cache[i].Data!=AuxData.
- Reset asserted mid-sequence discards all in-flight messages; there is no recovery sequencing.

Optional Feature:
- Macro GERMAN_FIRE_CNT_EN.
- Defined: fire_cnt is a 16-bit saturating count of cycles with fired=1. It holds at 0xFFFF and is cleared by reset.
- Undefined: fire_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Shared package german_pkg holds:
  - cache_state_e and msg_cmd_e enums.
  - rule_id_e enum and RULE_CNT=12.
  - struct types for cache entry and channel message, parametrised by DATA_W via typedef in the top.
- Sub-module german_node_slice: one instance per node.
  - Holds Cache, Chan1-3, InvSet, ShrSet.
  - Takes decoded per-node write strobes and values from the top.
  - Top keeps globals, guard decode and invariants.

Test Plan:
- Reset with inputs idle -> all cache_state=0, cur_cmd=0, ex_gntd=0, ctrl_ok=data_ok=1, fire_cnt=0.
- N=3: SendReqE(1), RecvReqE(1), SendGntE(1), RecvGntE(1), each with fired=1 -> cache_state=6'b001000, ex_gntd=1.
- Continue: Store(1,d=3), SendReqS(0), RecvReqS(0), SendInv(1), SendInvAck(1), RecvInvAck(1), SendGntS(0), RecvGntS(0).
  - Required: MemData=3, ex_gntd=0, node0 S with data 3, node1 I, data_ok=1 throughout.
- RecvGntS(2) with Chan2[2] Empty -> fired=0, no state change. rule_node=3 -> illegal_sel=1, fired=0. rule_id=13 -> illegal_sel=1.
- Assert reset asynchronously between edges mid-sequence -> state clears before the next edge; next edge applies nothing while reset is high.
- GERMAN_FIRE_CNT_EN defined: 8 fired + 2 non-fired cycles -> fire_cnt=8. Undefined -> fire_cnt=0.
